// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, sign fix-up in a final cycle, and
// single-cycle completion for divide-by-zero and signed overflow.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done,
    output logic             o_busy
);

    // state | meaning
    // IDLE  | waiting for i_start; special cases complete from here
    // DIV   | one restoring-division step per cycle, counter counts down
    // FIX   | apply quotient/remainder signs, publish results, pulse done
    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [5:0]       cnt;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Operand magnitudes and the trial subtraction of the current step
    always_comb begin
        a_neg  = i_signed & i_a[WIDTH-1];
        b_neg  = i_signed & i_b[WIDTH-1];
        a_mag  = a_neg ? -i_a : i_a;
        b_mag  = b_neg ? -i_b : i_b;
        rem_sh = {rem, dividend[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor};
    end

    // Division FSM with registered results, done and busy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            dividend    <= '0;
            divisor     <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (i_b == '0) begin
                            o_quotient  <= '1;
                            o_remainder <= i_a;
                            o_done      <= 1'b1;
                        end else if (i_signed && i_a == MIN_NEG && i_b == '1) begin
                            o_quotient  <= MIN_NEG;
                            o_remainder <= '0;
                            o_done      <= 1'b1;
                        end else begin
                            dividend <= a_mag;
                            divisor  <= b_mag;
                            rem      <= '0;
                            cnt      <= 6'(WIDTH);
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            o_busy   <= 1'b1;
                            state    <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (!diff[WIDTH]) begin
                        rem      <= diff[WIDTH-1:0];
                        dividend <= {dividend[WIDTH-2:0], 1'b1};
                    end else begin
                        rem      <= rem_sh[WIDTH-1:0];
                        dividend <= {dividend[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    o_quotient  <= neg_q ? -dividend : dividend;
                    o_remainder <= neg_r ? -rem : rem;
                    o_done      <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, control
// sequences (ignored start, mid-run reset) and back-to-back random ops
// against a reference model of RISC-V DIV/DIVU/REM/REMU.
module tb_divider;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_done;
    logic        o_busy;

    int n_checks = 0;
    int n_fails  = 0;

    divider #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_signed   (i_signed),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder),
        .o_done     (o_done),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic bit is_special(input bit s, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called right after the start edge; returns edges until o_done is seen.
    task automatic wait_done(output int lat, output bit busy_seen, output bit first_busy);
        lat        = 0;
        first_busy = o_busy;
        busy_seen  = o_busy;
        while (!o_done && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
            if (o_busy) busy_seen = 1'b1;
        end
    endtask

    task automatic start_pulse(input bit s, input logic [31:0] a, input logic [31:0] b);
        i_signed = s;
        i_a      = a;
        i_b      = b;
        i_start  = 1'b1;
        @(posedge i_clk); #1;
        i_start  = 1'b0;
    endtask

    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input int elat);
        int lat;
        bit busy_seen;
        bit first_busy;
        start_pulse(s, a, b);
        wait_done(lat, busy_seen, first_busy);
        chk({tag, " quotient"}, o_quotient, eq);
        chk({tag, " remainder"}, o_remainder, er);
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        if (elat == 0) chk({tag, " busy never"}, {31'b0, busy_seen}, 32'd0);
        else           chk({tag, " busy after start"}, {31'b0, first_busy}, 32'd1);
        @(posedge i_clk); #1;
        chk({tag, " done one cycle"}, {31'b0, o_done}, 32'd0);
        chk({tag, " quotient held"}, o_quotient, eq);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        bit          busy_seen;
        bit          first_busy;
        bit          seen_done;
        bit          cs;
        logic [31:0] ca, cb, cq, cr;
        bit          ns;
        logic [31:0] na, nb;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[3]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{1'b1, 32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  32'h1234_5678,  0};
        vecs[5]  = '{1'b0, 32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  32'h1234_5678,  0};
        vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          0};
        vecs[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  33};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'h0,          33};
        vecs[9]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'h0,          33};
        vecs[10] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          33};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'h0,          33};
        vecs[12] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'h0,          33};
        vecs[13] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'h0,          33};

        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_signed = 1'b0;
        i_a      = '0;
        i_b      = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset quotient", o_quotient, 32'h0);
        chk("reset remainder", o_remainder, 32'h0);
        chk("reset done", {31'b0, o_done}, 32'd0);
        chk("reset busy", {31'b0, o_busy}, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].lat);
        end

        // Start pulse during a busy division must be ignored.
        start_pulse(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge i_clk);
        #1;
        i_signed = 1'b1; i_a = 32'd50; i_b = 32'd5; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(lat, busy_seen, first_busy);
        chk("ignored start quotient", o_quotient, 32'd14);
        chk("ignored start remainder", o_remainder, 32'd2);
        chk("ignored start latency", 32'(lat + 10), 32'd33);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) seen_done = 1'b1;
        end
        chk("ignored start no restart", {31'b0, seen_done}, 32'd0);

        // Reset in the middle of a division aborts it.
        start_pulse(1'b0, 32'd1000, 32'd3);
        repeat (19) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("abort quotient", o_quotient, 32'h0);
        chk("abort remainder", o_remainder, 32'h0);
        chk("abort busy", {31'b0, o_busy}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) seen_done = 1'b1;
        end
        chk("abort no done", {31'b0, seen_done}, 32'd0);
        run_op("after reset", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

        // Back-to-back random operations, new start issued while o_done is high.
        cs = 1'b1; ca = 32'hFFFF_FF9C; cb = 32'd7;
        ref_div(cs, ca, cb, cq, cr);
        start_pulse(cs, ca, cb);
        for (int i = 0; i < 200; i++) begin
            wait_done(lat, busy_seen, first_busy);
            chk($sformatf("rand%0d quotient", i), o_quotient, cq);
            chk($sformatf("rand%0d remainder", i), o_remainder, cr);
            chk($sformatf("rand%0d latency", i), 32'(lat),
                is_special(cs, ca, cb) ? 32'd0 : 32'd33);
            if (i < 199) begin
                ns = 1'($urandom_range(0, 1));
                na = pick_val();
                nb = pick_val();
                start_pulse(ns, na, nb);
                if (!is_special(ns, na, nb)) begin
                    chk($sformatf("rand%0d held quotient", i), o_quotient, cq);
                    chk($sformatf("rand%0d done cleared", i), {31'b0, o_done}, 32'd0);
                end
                cs = ns; ca = na; cb = nb;
                ref_div(cs, ca, cb, cq, cr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
